ifm_window_buf: RTL and testbench
=================================

Name: ifm_window_buf

Overview:
- Parametrised multi-channel sliding-window input-feature-map buffer for the conv datapath.
- Accepts one IFM sample per channel per handshake into K-tap shift registers, one per channel.
- Emits the full K-tap window for all channels to the MAC array under valid/ready flow control.
- Supports runtime stride, row boundaries and short-row detection.

Parameters:
- DATA_W, 8, signed sample width in bits.
- K, 5, taps per channel (window length), K >= 2.
- NUM_CH, 4, parallel channels sharing one handshake.
- STRIDE_W, 3, width of cfg_stride.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous soft clear of row state. Taps are kept.
- cfg_stride  in  STRIDE_W  window stride. 0 is treated as 1. Latched at first accept of each row.
- in_valid  in  1  input sample valid.
- in_ready  out  1  buffer can accept.
- in_data  in  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
- in_last  in  1  marks the last sample of a row.
- out_valid  out  1  window valid.
- out_ready  in  1  consumer accepts window.
- out_data  out  NUM_CH*K*DATA_W  channel c, tap k at bits [(c*K+k)*DATA_W +: DATA_W]. Tap 0 is newest.
- out_last  out  1  window is the last of its row.
- err_short_row  out  1  sticky flag: a row ended with fewer than K samples.

Behaviour:
- Reset: all taps 0, fill_cnt 0, phase 0, stride_q 1. Outputs in reset: out_valid 0, out_last 0, err_short_row 0, in_ready 1.
- Reset mid-row discards the row. No window is emitted for it.
- Handshake rules:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Taps shift only on accept. For every channel, tap[k] <= tap[k-1] and tap[0] <= in_data lane.
- out_data is driven directly from the tap registers. It is therefore stable while out_valid && !out_ready.
- fill_cnt, 0..K, saturating: on accept, fill_next = min(fill_cnt+1, K).
- On accept with fill_cnt == 0, stride_q <= max(cfg_stride, 1).
- Emit decision on accept:
  - emit = (fill_next == K) && (phase == 0).
  - If fill_next == K, phase <= (phase+1 == stride_q) ? 0 : phase+1. Otherwise phase stays 0.
  - The first full window of a row is always emitted. After that, one of every stride_q accepts is emitted.
- Latency: out_valid rises 1 cycle after the accepting edge and stays high until transferred.
- out_valid update each cycle:
  - accept: out_valid <= emit.
  - transfer without accept: out_valid <= 0.
  - neither: hold.
- Simultaneous transfer and accept in the same cycle is legal and gives full throughput: 1 sample per cycle at stride 1.
- out_last <= emit && in_last, updated on accept.
- in_last accept:
  - After the shift, fill_cnt <= 0 and phase <= 0.
  - If fill_next < K, set err_short_row. No window is produced for that row.
  - A stride-skipped last sample produces no out_last. The consumer uses row length for that case.
- clr: fill_cnt <= 0, phase <= 0, out_valid <= 0, out_last <= 0, err_short_row <= 0. Taps unchanged. If clr and accept happen in the same cycle, clr wins and the sample is dropped.
- Arithmetic: none on data. Samples are moved bit-exact, sign preserved.
- Counters: fill_cnt width clog2(K+1). Phase width STRIDE_W.

Decomposition:
- Shared package cnn_pkg holds DATA_W, K, NUM_CH defaults, and helper function clog2 for the counter widths.
- Sub-module ifm_shift_lane: one channel, K-tap shift register.
  - Ports: clk, rst, en, din[DATA_W], taps[K*DATA_W].
  - Instantiated NUM_CH times via generate.
- Control (fill, phase, handshake, flags) stays in ifm_window_buf.

Test Plan:
- Config K=5, NUM_CH=2, stride 1. Stream a row of 8 samples, values 1..8 on ch0 and -1..-8 on ch1, out_ready=1, in_last on 8.
  - Expect 4 windows. The first has ch0 taps (5,4,3,2,1) and ch1 (-5..-1).
  - out_valid is high on 4 consecutive cycles. out_last is set only on window (8,7,6,5,4).
- Stride 2, row of 9 samples 1..9, in_last on 9.
  - Expect windows newest=5, 7, 9, with out_last on newest=9.
  - Stride 3, same row: expect newest=5, 8. No out_last.
- Backpressure: hold out_ready=0 for 4 cycles after the first window at stride 1.
  - in_ready=0 throughout and out_data stable at (5,4,3,2,1).
  - Release: streaming resumes with no sample lost or duplicated.
- Short row: 3 samples with in_last.
  - No out_valid, err_short_row=1.
  - The next 5-sample row yields 1 window of its own samples only. clr then drops err_short_row to 0.
- Reset mid-row: after 3 samples assert rst for 1 cycle.
  - All outputs are 0 and in_ready=1.
  - A fresh 5-sample row gives exactly 1 window with no stale data.
- Simultaneous clr and in_valid: the sample is dropped and fill stays 0, confirmed by the next 5 samples producing the first window.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared defaults and width helper for the conv datapath
package cnn_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int K_DEF = 5;
  localparam int NUM_CH_DEF = 4;
  function automatic int clog2(input int v);
    int r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/ifm_shift_lane.sv
// ifm_shift_lane: one-channel K-tap shift register, tap 0 newest
//   clk, rst : clock, synchronous active-high reset (taps to 0)
//   en       : shift enable
//   din      : incoming sample
//   taps     : tap k at [k*DATA_W +: DATA_W]
module ifm_shift_lane
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K = K_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DATA_W-1:0]   din,
  output logic [K*DATA_W-1:0] taps
);
  always_ff @(posedge clk)
    if (rst) taps <= '0;
    else if (en) taps <= {taps[(K-1)*DATA_W-1:0], din};
endmodule

// File: rtl/ifm_window_buf.sv
// ifm_window_buf: multi-channel sliding-window IFM buffer with stride and row control
//   clk, rst      : clock, synchronous active-high reset
//   clr           : soft clear of row state and flags, taps kept
//   cfg_stride    : window stride (0 acts as 1), latched on first sample of a row
//   in_*          : sample handshake, in_last marks end of row
//   out_*         : window handshake, out_data is channel c tap k at (c*K+k)*DATA_W
//   err_short_row : sticky, a row ended with fewer than K samples
module ifm_window_buf
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K = K_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int STRIDE_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [STRIDE_W-1:0]        cfg_stride,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CH*K*DATA_W-1:0] out_data,
  output logic                       out_last,
  output logic                       err_short_row
);
  localparam int FW = clog2(K + 1);
  logic [FW-1:0] fill_cnt, fill_next;
  logic [STRIDE_W-1:0] phase, stride_q;
  logic acc, full, emit, wrap;
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  assign fill_next = (fill_cnt == FW'(K)) ? fill_cnt : fill_cnt + FW'(1);
  assign full = fill_next == FW'(K);
  assign emit = full && phase == '0;
  // widened so phase+1 cannot overflow before the compare
  assign wrap = ((STRIDE_W+1)'(phase) + (STRIDE_W+1)'(1)) == (STRIDE_W+1)'(stride_q);
  // a sample arriving with clr is dropped, so taps do not shift either
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    ifm_shift_lane #(.DATA_W(DATA_W), .K(K)) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (acc && !clr),
      .din (in_data[c*DATA_W +: DATA_W]),
      .taps(out_data[c*K*DATA_W +: K*DATA_W])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
      phase <= '0;
      stride_q <= STRIDE_W'(1);
      out_valid <= 1'b0;
      out_last <= 1'b0;
      err_short_row <= 1'b0;
    end else if (clr) begin
      fill_cnt <= '0;
      phase <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      err_short_row <= 1'b0;
    end else if (acc) begin
      out_valid <= emit;
      out_last <= emit && in_last;
      if (fill_cnt == '0) stride_q <= (cfg_stride == '0) ? STRIDE_W'(1) : cfg_stride;
      if (in_last) begin
        fill_cnt <= '0;
        phase <= '0;
        if (!full) err_short_row <= 1'b1;
      end else begin
        fill_cnt <= fill_next;
        phase <= !full ? '0 : wrap ? '0 : phase + STRIDE_W'(1);
      end
    end else if (out_ready) out_valid <= 1'b0;
  end
endmodule

// File: tb/tb_ifm_window_buf.sv
// tb_ifm_window_buf: randomized self-checking bench against a row-level window model
module tb_ifm_window_buf;
  localparam int DW = 8, KK = 5, NC = 2, SW = 3, OW = NC * KK * DW;
  logic clk = 0, rst = 1, clr = 0;
  logic [SW-1:0] cfg_stride = 1;
  logic in_valid = 0, in_ready, in_last = 0;
  logic [NC*DW-1:0] in_data = '0;
  logic out_valid, out_ready = 1, out_last, err_short_row;
  logic [OW-1:0] out_data;
  int checks = 0, errors = 0, cyc = 0;
  bit bp = 0;
  int r0[64], r1[64];
  logic [OW-1:0] exp_d[$], rcv_d[$];
  bit exp_l[$], rcv_l[$];
  int rcv_t[$];

  ifm_window_buf #(.DATA_W(DW), .K(KK), .NUM_CH(NC), .STRIDE_W(SW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .cfg_stride(cfg_stride),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .err_short_row(err_short_row)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      rcv_d.push_back(out_data);
      rcv_l.push_back(out_last);
      rcv_t.push_back(cyc);
    end
  always @(posedge clk) begin
    #1;
    if (bp) out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic clrq();
    exp_d.delete(); exp_l.delete(); rcv_d.delete(); rcv_l.delete(); rcv_t.delete();
  endtask

  task automatic fill_seq(input int n);
    for (int i = 0; i < n; i++) begin r0[i] = i + 1; r1[i] = -(i + 1); end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      r0[i] = int'($urandom_range(0, 255)) - 128;
      r1[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // windows exist at the K-th sample of the row and every stride-th sample after it
  task automatic build_exp(input int n, input int s, input bit last);
    int se = (s == 0) ? 1 : s;
    logic [OW-1:0] w;
    for (int i = KK - 1; i < n; i++)
      if ((i + 1 - KK) % se == 0) begin
        for (int c = 0; c < NC; c++)
          for (int k = 0; k < KK; k++)
            w[(c*KK+k)*DW +: DW] = DW'(c == 0 ? r0[i-k] : r1[i-k]);
        exp_d.push_back(w);
        exp_l.push_back(last && i == n - 1);
      end
  endtask

  task automatic drive(input int v0, input int v1, input bit last);
    bit ok;
    int t = 0;
    in_valid = 1; in_data = {DW'(v1), DW'(v0)}; in_last = last;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; t++;
    end while (!ok && t < 200);
    if (!ok) begin checks++; errors++; $display("FAIL accept_timeout got in_ready=0 want 1"); end
    in_valid = 0; in_last = 0;
  endtask

  task automatic send_row(input int n, input bit last);
    for (int i = 0; i < n; i++) drive(r0[i], r1[i], last && i == n - 1);
  endtask

  task automatic drain();
    bp = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", out_last); end
    if (err_short_row !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err_short_row); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic test_stride1();
    logic [OW-1:0] w0 = {8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    clrq(); cfg_stride = 1; fill_seq(8); build_exp(8, 1, 1);
    send_row(8, 1); drain();
    checks++;
    if (rcv_d.size() !== exp_d.size()) begin errors++; $display("FAIL s1_count got %0d want %0d", rcv_d.size(), exp_d.size()); end
    else for (int i = 0; i < exp_d.size(); i++) begin
      checks += 2;
      if (rcv_d[i] !== exp_d[i] || rcv_l[i] !== exp_l[i]) begin errors++; $display("FAIL s1_win%0d got %h/%b want %h/%b", i, rcv_d[i], rcv_l[i], exp_d[i], exp_l[i]); end
      if (rcv_t[i] !== rcv_t[0] + i) begin errors++; $display("FAIL s1_consec%0d got cycle %0d want %0d", i, rcv_t[i], rcv_t[0] + i); end
    end
    if (rcv_d.size() > 0) begin
      checks++;
      if (rcv_d[0] !== w0) begin errors++; $display("FAIL s1_first got %h want %h", rcv_d[0], w0); end
    end
  endtask

  task automatic test_stride();
    int st[3] = '{2, 3, 0};
    for (int j = 0; j < 3; j++) begin
      clrq(); cfg_stride = SW'(st[j]); fill_seq(9); build_exp(9, st[j], 1);
      send_row(9, 1); drain();
      checks++;
      if (rcv_d.size() !== exp_d.size()) begin errors++; $display("FAIL stride%0d_count got %0d want %0d", st[j], rcv_d.size(), exp_d.size()); end
      else for (int i = 0; i < exp_d.size(); i++) begin
        checks++;
        if (rcv_d[i] !== exp_d[i] || rcv_l[i] !== exp_l[i]) begin errors++; $display("FAIL stride%0d_win%0d got %h/%b want %h/%b", st[j], i, rcv_d[i], rcv_l[i], exp_d[i], exp_l[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    clrq(); cfg_stride = 1; fill_seq(9); build_exp(9, 1, 1);
    bp = 0; out_ready = 0;
    fork
      send_row(9, 1);
      begin
        int t = 0;
        do begin @(negedge clk); t++; end while (!out_valid && t < 100);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_wait got out_valid=%b want 1", out_valid); end
        for (int i = 0; i < 4; i++) begin
          checks += 2;
          if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %b want 0", i, in_ready); end
          if (out_data !== exp_d[0]) begin errors++; $display("FAIL bp_stable%0d got %h want %h", i, out_data, exp_d[0]); end
          @(negedge clk);
        end
        @(posedge clk); #1; out_ready = 1;
      end
    join
    drain();
    checks++;
    if (rcv_d.size() !== exp_d.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", rcv_d.size(), exp_d.size()); end
    else for (int i = 0; i < exp_d.size(); i++) begin
      checks++;
      if (rcv_d[i] !== exp_d[i] || rcv_l[i] !== exp_l[i]) begin errors++; $display("FAIL bp_win%0d got %h/%b want %h/%b", i, rcv_d[i], rcv_l[i], exp_d[i], exp_l[i]); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(5, 14);
      int s = $urandom_range(0, 7);
      clrq(); cfg_stride = SW'(s); fill_rand(n); build_exp(n, s, 1);
      bp = 1; send_row(n, 1); drain();
      checks++;
      if (rcv_d.size() !== exp_d.size()) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", r, rcv_d.size(), exp_d.size()); end
      else for (int i = 0; i < exp_d.size(); i++) begin
        checks++;
        if (rcv_d[i] !== exp_d[i] || rcv_l[i] !== exp_l[i]) begin errors++; $display("FAIL rnd%0d_win%0d got %h/%b want %h/%b", r, i, rcv_d[i], rcv_l[i], exp_d[i], exp_l[i]); end
      end
    end
  endtask

  task automatic test_short_row();
    clrq(); cfg_stride = 1; fill_seq(3);
    send_row(3, 1); drain();
    checks += 2;
    if (rcv_d.size() !== 0) begin errors++; $display("FAIL short_windows got %0d want 0", rcv_d.size()); end
    if (err_short_row !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", err_short_row); end
    clrq(); fill_rand(5); build_exp(5, 1, 1);
    send_row(5, 1); drain();
    checks += 2;
    if (err_short_row !== 1'b1) begin errors++; $display("FAIL short_sticky got %b want 1", err_short_row); end
    if (rcv_d.size() !== exp_d.size()) begin errors++; $display("FAIL short_next_count got %0d want %0d", rcv_d.size(), exp_d.size()); end
    else for (int i = 0; i < exp_d.size(); i++) begin
      checks++;
      if (rcv_d[i] !== exp_d[i] || rcv_l[i] !== exp_l[i]) begin errors++; $display("FAIL short_next_win%0d got %h/%b want %h/%b", i, rcv_d[i], rcv_l[i], exp_d[i], exp_l[i]); end
    end
    clr = 1; @(posedge clk); #1; clr = 0;
    @(negedge clk);
    checks++;
    if (err_short_row !== 1'b0) begin errors++; $display("FAIL short_clr got %b want 0", err_short_row); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_row();
    clrq(); cfg_stride = 1; fill_seq(3);
    send_row(3, 0);
    rst = 1; @(posedge clk); #1; rst = 0;
    @(negedge clk);
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
    if (out_last !== 1'b0) begin errors++; $display("FAIL mid_out_last got %b want 0", out_last); end
    if (err_short_row !== 1'b0) begin errors++; $display("FAIL mid_err got %b want 0", err_short_row); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
    if (out_data !== '0) begin errors++; $display("FAIL mid_taps got %h want 0", out_data); end
    @(posedge clk); #1;
    fill_rand(5); build_exp(5, 1, 1);
    send_row(5, 1); drain();
    checks++;
    if (rcv_d.size() !== exp_d.size()) begin errors++; $display("FAIL mid_count got %0d want %0d", rcv_d.size(), exp_d.size()); end
    else for (int i = 0; i < exp_d.size(); i++) begin
      checks++;
      if (rcv_d[i] !== exp_d[i] || rcv_l[i] !== exp_l[i]) begin errors++; $display("FAIL mid_win%0d got %h/%b want %h/%b", i, rcv_d[i], rcv_l[i], exp_d[i], exp_l[i]); end
    end
  endtask

  task automatic test_clr_accept();
    clrq(); cfg_stride = 1; fill_rand(2);
    send_row(2, 0);
    in_valid = 1; in_data = {8'h55, 8'h7F}; clr = 1;
    @(posedge clk); #1;
    in_valid = 0; clr = 0;
    fill_rand(5); build_exp(5, 1, 1);
    send_row(5, 1); drain();
    checks++;
    if (rcv_d.size() !== exp_d.size()) begin errors++; $display("FAIL clr_count got %0d want %0d", rcv_d.size(), exp_d.size()); end
    else for (int i = 0; i < exp_d.size(); i++) begin
      checks++;
      if (rcv_d[i] !== exp_d[i] || rcv_l[i] !== exp_l[i]) begin errors++; $display("FAIL clr_win%0d got %h/%b want %h/%b", i, rcv_d[i], rcv_l[i], exp_d[i], exp_l[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_stride1();
    test_stride();
    test_backpressure();
    test_random();
    test_short_row();
    test_reset_mid_row();
    test_clr_accept();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
